seg7_scan_driver: RTL and testbench

//   Multiplexed N-digit 7-segment display driver; parametrised successor of the single-digit 4-bit -> 7-seg decoder.

---
 rtl/seg7_pkg.sv | 26 ++
 rtl/seg7_hex_decode.sv | 35 +++
 rtl/seg7_scan_driver.sv | 152 +++++++++++++++
 tb/tb_seg7_scan_driver.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared segment encodings for the 7-segment scan driver.
// Bit order is {g,f,e,d,c,b,a}, and a 1 means the segment is lit.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0    = 7'h3F;
  localparam seg_t SEG_1    = 7'h06;
  localparam seg_t SEG_2    = 7'h5B;
  localparam seg_t SEG_3    = 7'h4F;
  localparam seg_t SEG_4    = 7'h66;
  localparam seg_t SEG_5    = 7'h6D;
  localparam seg_t SEG_6    = 7'h7D;
  localparam seg_t SEG_7    = 7'h07;
  localparam seg_t SEG_8    = 7'h7F;
  localparam seg_t SEG_9    = 7'h6F;
  localparam seg_t SEG_A    = 7'h77;
  localparam seg_t SEG_B    = 7'h7C;
  localparam seg_t SEG_C    = 7'h39;
  localparam seg_t SEG_D    = 7'h5E;
  localparam seg_t SEG_E    = 7'h79;
  localparam seg_t SEG_F    = 7'h71;
  localparam seg_t SEG_DASH = 7'h40;
  localparam seg_t SEG_OFF  = 7'h00;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to 7-segment decoder.
// Nibbles above 9 are shown as A..F when hex_en=1, and as a dash otherwise.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex_en,
  output seg_t       seg
);

  // Table lookup, with the letters gated by hex_en.
  always_comb begin
    seg = SEG_OFF;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = hex_en ? SEG_A : SEG_DASH;
      4'hB: seg = hex_en ? SEG_B : SEG_DASH;
      4'hC: seg = hex_en ? SEG_C : SEG_DASH;
      4'hD: seg = hex_en ? SEG_D : SEG_DASH;
      4'hE: seg = hex_en ? SEG_E : SEG_DASH;
      4'hF: seg = hex_en ? SEG_F : SEG_DASH;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit 7-segment scan driver.
// - The load strobe latches the word into pending registers.
// - Each digit slot starts with one dark gap cycle. During that cycle the
//   pending registers are copied to the shadow registers.
// - The remaining cycles of the slot drive the selected digit from the
//   shadow registers, so a digit never changes partway through its slot.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int N_DIGITS   = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  load,
  input  logic                  blank_lz,
  input  logic                  hex_en,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   an
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  typedef enum logic {GAP, SHOW} state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic [4*N_DIGITS-1:0] pend_val;
  logic [4*N_DIGITS-1:0] shad_val;
  logic [N_DIGITS-1:0]   pend_dp;
  logic [N_DIGITS-1:0]   shad_dp;

  logic [N_DIGITS-1:0]   lz;
  logic                  lz_run;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_lz;
  logic [N_DIGITS-1:0]   onehot;
  logic                  blanked;
  seg_t                  dec_seg;

  logic [N_DIGITS-1:0]   an_q;
  seg_t                  seg_q;
  logic                  dp_q;

  // Pending capture: the last load strobe wins, and a load during reset is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_val <= '0;
      pend_dp  <= '0;
    end else if (load) begin
      pend_val <= value;
      pend_dp  <= dp_in;
    end
  end

  // Slot sequencer.
  // - GAP lasts one prescaler count and commits pending to shadow.
  // - SHOW lasts until the prescaler wraps, then advances the digit index.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= GAP;
      cnt      <= '0;
      idx      <= '0;
      shad_val <= '0;
      shad_dp  <= '0;
    end else begin
      case (state)
        GAP: begin
          shad_val <= pend_val;
          shad_dp  <= pend_dp;
          cnt      <= CNT_W'(1);
          state    <= SHOW;
        end
        SHOW: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= GAP;
            idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= GAP;
      endcase
    end
  end

  // Leading-zero map: lz[i] is set when shadow nibbles N_DIGITS-1..i are all zero.
  always_comb begin
    lz     = '0;
    lz_run = 1'b1;
    for (int unsigned k = 0; k < N_DIGITS; k++) begin
      lz_run                = lz_run & (shad_val[4*(N_DIGITS-1-k) +: 4] == 4'h0);
      lz[N_DIGITS-1-k]      = lz_run;
    end
  end

  // Select the current digit's nibble, dp, zero flag and anode bit.
  always_comb begin
    cur_nib = 4'h0;
    cur_dp  = 1'b0;
    cur_lz  = 1'b0;
    onehot  = '0;
    for (int unsigned k = 0; k < N_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        cur_nib   = shad_val[4*k +: 4];
        cur_dp    = shad_dp[k];
        cur_lz    = lz[k];
        onehot[k] = 1'b1;
      end
    end
    blanked = blank_lz && (idx != '0) && cur_lz;
  end

  seg7_hex_decode u_dec (
    .nibble (cur_nib),
    .hex_en (hex_en),
    .seg    (dec_seg)
  );

  // Registered pin image, one cycle behind the sequencer.
  // A blanked digit keeps its anode on only when its dp must be shown.
  always_ff @(posedge clk) begin
    if (rst) begin
      an_q  <= '0;
      seg_q <= SEG_OFF;
      dp_q  <= 1'b0;
    end else if (state == SHOW) begin
      an_q  <= (blanked && !cur_dp) ? '0 : onehot;
      seg_q <= blanked ? SEG_OFF : dec_seg;
      dp_q  <= cur_dp;
    end else begin
      an_q  <= '0;
      seg_q <= SEG_OFF;
      dp_q  <= 1'b0;
    end
  end

  assign an  = (ACTIVE_LOW != 0) ? ~an_q  : an_q;
  assign seg = (ACTIVE_LOW != 0) ? ~seg_q : seg_q;
  assign dp  = (ACTIVE_LOW != 0) ? ~dp_q  : dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: N_DIGITS=4, SCAN_DIV=4, active-high pins.
// Cycle k counts negedges after rst is released.
// - Digit d of the frame starting at cycle B has its gap at B+4d and shows
//   at B+4d+1..B+4d+3.
// - Frames start at 1, 17, 33, ...
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        load;
  logic        blank_lz;
  logic        hex_en;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  seg7_scan_driver #(
    .N_DIGITS   (4),
    .SCAN_DIV   (4),
    .ACTIVE_LOW (0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .value    (value),
    .dp_in    (dp_in),
    .load     (load),
    .blank_lz (blank_lz),
    .hex_en   (hex_en),
    .seg      (seg),
    .dp       (dp),
    .an       (an)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic goto(input int k);
    while (cyc < k) step();
  endtask

  // Pins packed as {an, dp, seg}.
  function automatic logic [11:0] pins();
    return {an, dp, seg};
  endfunction

  task automatic expect_at(input string tag, input int k, input logic [3:0] e_an,
                           input logic e_dp, input logic [6:0] e_seg);
    goto(k);
    check($sformatf("%s@%0d", tag, k), {20'd0, pins()}, {20'd0, e_an, e_dp, e_seg});
  endtask

  // segs = {s3,s2,s1,s0}; anm selects which anodes are expected lit; dpm gives the expected dp.
  task automatic check_frame(input string tag, input int base, input logic [27:0] segs,
                             input logic [3:0] anm, input logic [3:0] dpm);
    for (int d = 0; d < 4; d++) begin
      logic [3:0] oh;
      oh = 4'b0001 << d;
      expect_at({tag, "_gap"}, base + 4*d, 4'b0000, 1'b0, 7'h00);
      for (int p = 1; p < 4; p++)
        expect_at($sformatf("%s_d%0d", tag, d), base + 4*d + p,
                  anm[d] ? oh : 4'b0000, dpm[d], segs[7*d +: 7]);
    end
  endtask

  task automatic load_word(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp_in = d;
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; value = '0; dp_in = '0; load = 1'b0; blank_lz = 1'b0; hex_en = 1'b1;

    // 1: reset holds all pins off, then digit 0 shows on the 2nd cycle after release.
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_off", {20'd0, pins()}, 32'd0);
    end
    rst = 1'b0;
    cyc = 0;
    expect_at("rel_gap", 1, 4'b0000, 1'b0, 7'h00);
    expect_at("rel_d0", 2, 4'b0001, 1'b0, 7'h3F);

    // 2: 1234 scans as 4,3,2,1, then wraps back to digit 0.
    load_word(16'h1234, 4'b0000);
    check_frame("scan1234", 17, {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b1111, 4'b0000);
    expect_at("wrap", 34, 4'b0001, 1'b0, 7'h66);

    // 3: leading-zero blanking; a blanked digit with dp keeps its anode on.
    goto(35);
    blank_lz = 1'b1;
    load_word(16'h0040, 4'b0000);
    check_frame("blank", 49, {7'h00, 7'h00, 7'h66, 7'h3F}, 4'b0011, 4'b0000);
    goto(66);
    load_word(16'h0040, 4'b0100);
    check_frame("blank_dp", 81, {7'h00, 7'h00, 7'h66, 7'h3F}, 4'b0111, 4'b0100);

    // 4: nibble A shows as a dash with hex off, and as 'A' with hex on.
    goto(98);
    blank_lz = 1'b0;
    hex_en   = 1'b0;
    load_word(16'h00A0, 4'b0000);
    check_frame("dash", 113, {7'h3F, 7'h3F, 7'h40, 7'h3F}, 4'b1111, 4'b0000);
    goto(130);
    hex_en = 1'b1;
    check_frame("hexA", 145, {7'h3F, 7'h3F, 7'h77, 7'h3F}, 4'b1111, 4'b0000);

    // 5: a load in the middle of digit 2's slot takes effect at the next slot boundary.
    goto(162);
    load_word(16'h1234, 4'b0000);
    check_frame("re1234", 177, {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b1111, 4'b0000);
    expect_at("mid_d2", 202, 4'b0100, 1'b0, 7'h5B);
    load_word(16'h5555, 4'b0000);
    expect_at("hold_d2", 203, 4'b0100, 1'b0, 7'h5B);
    expect_at("hold_d2", 204, 4'b0100, 1'b0, 7'h5B);
    expect_at("new_gap", 205, 4'b0000, 1'b0, 7'h00);
    expect_at("new_d3", 206, 4'b1000, 1'b0, 7'h6D);
    expect_at("new_d0", 210, 4'b0001, 1'b0, 7'h6D);

    // 6: reset in the middle of a slot darkens the pins on the next cycle, and a load during reset is dropped.
    expect_at("pre_rst", 234, 4'b0100, 1'b0, 7'h6D);
    rst   = 1'b1;
    value = 16'h9999;
    load  = 1'b1;
    step();
    check("rst_mid", {20'd0, pins()}, 32'd0);
    step();
    check("rst_hold", {20'd0, pins()}, 32'd0);
    load = 1'b0;
    rst  = 1'b0;
    cyc  = 0;
    expect_at("rst2_gap", 1, 4'b0000, 1'b0, 7'h00);
    expect_at("rst2_d0", 2, 4'b0001, 1'b0, 7'h3F);
    expect_at("rst2_nold", 18, 4'b0001, 1'b0, 7'h3F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
